// File: rtl/fetch_buf.sv
// fetch_buf: instruction fetch buffer sitting directly upstream of the icache.
//
// It issues line fetch requests, captures in-order line responses into a small
// circular queue, and hands one instruction per cycle to decode. A redirect
// flushes the queue and bumps the epoch. Responses carrying an older epoch are
// then recognised by their id and dropped.
//
// Optional build macro: FB_RSP_BYPASS_EN. When it is defined, the first word of
// a line that targets an empty queue head goes to decode in the same cycle the
// response arrives. When it is undefined, that word appears one cycle later.
//
// Ports:
//   clk             clock
//   reset           asynchronous, active-high reset
//   fb_ic_req_nnn   registered line request {valid, id, addr}
//   ic_fb_rsp_nnn   line response {valid, id, data.W[CL_SZ_WORDS]}
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch PC (word aligned)
//   fb_de_valid     instruction available to decode
//   fb_de_instr     instruction word
//   fb_de_pc        PC of fb_de_instr
//   de_fb_ready     decode accepts this cycle

package fetch_buf_pkg;
  localparam int CL_SZ_WORDS = 4;
  localparam int MEM_ID_W    = 8;

  typedef struct packed {
    logic [CL_SZ_WORDS-1:0][31:0] W;
  } t_line;

  typedef struct packed {
    logic                valid;
    logic [MEM_ID_W-1:0] id;
    logic [31:0]         addr;
  } t_mem_req;

  typedef struct packed {
    logic                valid;
    logic [MEM_ID_W-1:0] id;
    t_line               data;
  } t_mem_rsp;
endpackage

module fetch_buf
  import fetch_buf_pkg::*;
#(
  parameter int          NUM_ENTRIES    = 4,
  parameter int          EPOCH_BITS     = 3,
  parameter int          ICACHE_LATENCY = 1,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output t_mem_req    fb_ic_req_nnn,
  input  t_mem_rsp    ic_fb_rsp_nnn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fb_de_valid,
  output logic [31:0] fb_de_instr,
  output logic [31:0] fb_de_pc,
  input  logic        de_fb_ready
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int WI_W  = (CL_SZ_WORDS > 1) ? $clog2(CL_SZ_WORDS) : 1;

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic [31:0]     LINE_BYTES = 32'(CL_SZ_WORDS * 4);
  localparam logic [WI_W-1:0] LAST_WORD  = WI_W'(CL_SZ_WORDS - 1);

  logic [1:0]            state_q   [NUM_ENTRIES];
  logic [1:0]            state_d   [NUM_ENTRIES];
  logic [31:0]           base_pc_q [NUM_ENTRIES];
  logic [31:0]           base_pc_d [NUM_ENTRIES];
  t_line                 data_q    [NUM_ENTRIES];
  t_line                 data_d    [NUM_ENTRIES];
  logic [IDX_W-1:0]      head_q, head_d;
  logic [IDX_W-1:0]      alloc_q, alloc_d;
  logic [WI_W-1:0]       word_idx_q, word_idx_d;
  logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
  logic [31:0]           fetch_pc_q, fetch_pc_d;
  t_mem_req              req_q, req_d;

  logic [IDX_W-1:0]      rsp_idx;
  logic [EPOCH_BITS-1:0] rsp_epoch;
  logic                  issue;
  logic                  capture;
  logic                  bypass;
  logic                  accept;
  logic                  unused_rsp_id_hi;

  assign rsp_idx   = ic_fb_rsp_nnn.id[IDX_W-1:0];
  assign rsp_epoch = ic_fb_rsp_nnn.id[IDX_W +: EPOCH_BITS];
  assign unused_rsp_id_hi = ^ic_fb_rsp_nnn.id;

  // Issue only into a FREE slot, so every response always has a home.
  assign issue   = (state_q[alloc_q] == ST_FREE) && !redirect_valid;
  assign capture = ic_fb_rsp_nnn.valid && (rsp_epoch == epoch_q) &&
                   (state_q[rsp_idx] == ST_PEND) && !redirect_valid;

`ifdef FB_RSP_BYPASS_EN
  // Capture already implies the target is PEND, so a head hit means the queue is empty.
  assign bypass = capture && (rsp_idx == head_q) && (word_idx_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign fb_de_valid = ((state_q[head_q] == ST_FULL) || bypass) && !redirect_valid;
  assign fb_de_instr = bypass ? ic_fb_rsp_nnn.data.W[0] : data_q[head_q].W[word_idx_q];
  assign fb_de_pc    = base_pc_q[head_q] + (32'(word_idx_q) << 2);
  assign accept      = fb_de_valid && de_fb_ready;

  assign fb_ic_req_nnn = req_q;

  always_comb begin
    state_d    = state_q;
    base_pc_d  = base_pc_q;
    data_d     = data_q;
    head_d     = head_q;
    alloc_d    = alloc_q;
    word_idx_d = word_idx_q;
    epoch_d    = epoch_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = '0;

    if (redirect_valid) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_d[i] = ST_FREE;
      end
      head_d     = '0;
      alloc_d    = '0;
      word_idx_d = '0;
      epoch_d    = epoch_q + EPOCH_BITS'(1);
      fetch_pc_d = redirect_pc;
    end else begin
      if (issue) begin
        state_d[alloc_q]   = ST_PEND;
        base_pc_d[alloc_q] = fetch_pc_q;
        fetch_pc_d         = fetch_pc_q + LINE_BYTES;
        alloc_d            = alloc_q + IDX_W'(1);
        req_d.valid        = 1'b1;
        req_d.id           = MEM_ID_W'({epoch_q, alloc_q});
        req_d.addr         = fetch_pc_q;
      end
      if (capture) begin
        state_d[rsp_idx] = ST_FULL;
        data_d[rsp_idx]  = ic_fb_rsp_nnn.data;
      end
      // Runs after capture so a bypassed line lands FULL at word 1 (or FREE for 1-word lines).
      if (accept) begin
        if (word_idx_q == LAST_WORD) begin
          state_d[head_q] = ST_FREE;
          head_d          = head_q + IDX_W'(1);
          word_idx_d      = '0;
        end else begin
          word_idx_d = word_idx_q + WI_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
      end
      head_q     <= '0;
      alloc_q    <= '0;
      word_idx_q <= '0;
      epoch_q    <= '0;
      fetch_pc_q <= RESET_PC;
      req_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      alloc_q    <= alloc_d;
      word_idx_q <= word_idx_d;
      epoch_q    <= epoch_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
    end
  end

  // Line payload carries no reset; its FREE/PEND/FULL state guards every read.
  always_ff @(posedge clk) begin
    base_pc_q <= base_pc_d;
    data_q    <= data_d;
  end

  // The epoch must outlive every response still in flight when a redirect lands.
  always @(posedge clk) begin
    if (!reset) begin
      assert (2**EPOCH_BITS > ICACHE_LATENCY + 1)
        else $error("fetch_buf: EPOCH_BITS too narrow for ICACHE_LATENCY");
      if (ic_fb_rsp_nnn.valid && (rsp_epoch == epoch_q)) begin
        assert (state_q[rsp_idx] == ST_PEND)
          else $error("fetch_buf: current-epoch response to a non-pending entry");
      end
    end
  end

endmodule

// File: tb/tb_fetch_buf.sv
// Testbench for fetch_buf. It pairs an icache model with latency 1 and data as
// a hash of the address with a sequence-level reference model. The reference
// model tracks the expected request address, expected id and expected next
// decode PC. Directed phases follow the test plan, then a randomized phase runs.
module tb_fetch_buf;
  import fetch_buf_pkg::*;

  localparam int          NE  = 4;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  t_mem_req    req;
  t_mem_rsp    rsp;
  logic        redir_v;
  logic [31:0] redir_pc;
  logic        de_v;
  logic [31:0] de_instr;
  logic [31:0] de_pc;
  logic        de_rdy;

  fetch_buf #(
    .NUM_ENTRIES(NE), .EPOCH_BITS(3), .ICACHE_LATENCY(1), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .reset(rst),
    .fb_ic_req_nnn(req), .ic_fb_rsp_nnn(rsp),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .fb_de_valid(de_v), .fb_de_instr(de_instr), .fb_de_pc(de_pc),
    .de_fb_ready(de_rdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // icache model: the request seen during one cycle is answered in the next cycle.
  t_mem_req prev_req;
  initial begin
    rsp      = '0;
    prev_req = '0;
    forever begin
      @(posedge clk);
      #1;
      rsp = '0;
      if (prev_req.valid) begin
        rsp.valid = 1'b1;
        rsp.id    = prev_req.id;
        for (int i = 0; i < CL_SZ_WORDS; i++) begin
          rsp.data.W[i] = mem_word(prev_req.addr + 32'(4 * i));
        end
      end
      prev_req = req;
    end
  end

  // Reference model: request stream and decode stream, restarted by reset/redirect.
  logic [31:0] m_req_addr;
  logic [31:0] m_pc;
  logic [31:0] prev_pc;
  logic [2:0]  m_epoch;
  int          m_issued;
  int          m_words;
  bit          flush_seen;
  bit          prev_stall;
  int          acc_cnt = 0;

  initial begin
    m_req_addr = RPC; m_pc = RPC; prev_pc = '0; m_epoch = '0;
    m_issued = 0; m_words = 0; flush_seen = 0; prev_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_req_addr = RPC; m_pc = RPC; m_epoch = '0;
        m_issued = 0; m_words = 0; flush_seen = 0; prev_stall = 0;
      end else begin
        if (flush_seen) begin
          check("flush_req_valid", 32'(req.valid), 32'd0);
          check("flush_de_valid", 32'(de_v), 32'd0);
          flush_seen = 0;
        end
        if (req.valid) begin
          check("req_addr", req.addr, m_req_addr);
          check("req_id", 32'(req.id), 32'({m_epoch, 2'(m_issued % NE)}));
          check("req_cap", 32'((m_issued - m_words / CL_SZ_WORDS) < NE), 32'd1);
          m_req_addr = m_req_addr + 32'(CL_SZ_WORDS * 4);
          m_issued++;
        end
        if (redir_v) begin
          check("redir_de_valid", 32'(de_v), 32'd0);
          m_epoch    = m_epoch + 3'd1;
          m_req_addr = redir_pc;
          m_pc       = redir_pc;
          m_issued   = 0;
          m_words    = 0;
          flush_seen = 1;
          prev_stall = 0;
        end else begin
          if (prev_stall) begin
            check("hold_valid", 32'(de_v), 32'd1);
            check("hold_pc", de_pc, prev_pc);
          end
          if (de_v) begin
            check("de_pc", de_pc, m_pc);
            check("de_instr", de_instr, mem_word(m_pc));
          end
          if (de_v && de_rdy) begin
            m_pc = m_pc + 32'd4;
            m_words++;
            acc_cnt++;
          end
          prev_stall = de_v && !de_rdy;
          prev_pc    = de_pc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_req_valid", 32'(req.valid), 32'd0);
    check("rst_req_addr", req.addr, 32'd0);
    check("rst_req_id", 32'(req.id), 32'd0);
    check("rst_de_valid", 32'(de_v), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Counts negedges until a request is visible; n = -1 if the bound expires.
  task automatic wait_req(input int bound, output int n, output logic [31:0] addr,
                          output logic [31:0] id);
    n = 0; addr = '0; id = '0;
    while (n < bound) begin
      @(negedge clk);
      n++;
      if (req.valid) begin
        addr = req.addr;
        id   = 32'(req.id);
        return;
      end
    end
    n = -1;
  endtask

  int          n, cnt, first_de, acc_start;
  logic [31:0] a, id, first_pc;
  bit          found;

  initial begin
    de_rdy = 1'b0; redir_v = 1'b0; redir_pc = '0;

    // Reset release, streaming with ready high.
    @(posedge clk); #1;
    de_rdy = 1'b1;
    do_reset();
    wait_req(10, n, a, id);
    check("first_req_cycle", 32'(n), 32'd2);
    check("first_req_addr", a, RPC);
    cnt = 0; first_de = -1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      cnt += int'(req.valid);
      if (de_v && first_de < 0) first_de = k;
    end
    check("req_burst", 32'(cnt), 32'd3);
    check("first_instr_latency", 32'(first_de), 32'd2);
    repeat (30) tick();

    // Ready held low: four requests, then a stable head.
    de_rdy = 1'b0;
    do_reset();
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      cnt += int'(req.valid);
    end
    check("stall_req_count", 32'(cnt), 32'd4);
    check("stall_de_valid", 32'(de_v), 32'd1);
    check("stall_de_pc", de_pc, 32'h0);
    tick();
    de_rdy = 1'b1;
    wait_req(10, n, a, id);
    check("refill_req_addr", a, 32'h40);
    check("refill_req_cycle", 32'(n), 32'd6);
    repeat (10) tick();

    // Redirect while lines are pending.
    do_reset();
    wait_req(10, n, a, id);
    @(negedge clk);
    tick();
    redir_v = 1'b1; redir_pc = 32'h104;
    tick();
    redir_v = 1'b0;
    wait_req(10, n, a, id);
    check("redir_req_cycle", 32'(n), 32'd2);
    check("redir_req_addr", a, 32'h104);
    check("redir_req_id", id, 32'h4);
    found = 0; first_pc = '1;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (de_v && first_pc == '1) first_pc = de_pc;
      if (de_v && de_rdy && de_pc == 32'h108) found = 1;
    end
    check("redir_first_pc", first_pc, 32'h104);
    check("redir_second_pc_taken", 32'(found), 32'd1);

    // Three back-to-back redirects: only the last takes effect.
    tick();
    do_reset();
    repeat (5) tick();
    redir_v = 1'b1; redir_pc = 32'h200;
    tick();
    redir_pc = 32'h300;
    tick();
    redir_pc = 32'h400;
    tick();
    redir_v = 1'b0;
    wait_req(10, n, a, id);
    check("multi_redir_cycle", 32'(n), 32'd2);
    check("multi_redir_addr", a, 32'h400);
    check("multi_redir_id", id, 32'hC);
    first_pc = '1;
    for (int k = 0; k < 12 && first_pc == '1; k++) begin
      @(negedge clk);
      if (de_v) first_pc = de_pc;
    end
    check("multi_redir_first_pc", first_pc, 32'h400);

    // Ready toggling across the 0xC -> 0x10 line boundary.
    tick();
    de_rdy = 1'b0;
    do_reset();
    repeat (8) tick();
    de_rdy = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("bnd_pc_c", de_pc, 32'hC);
    check("bnd_req_before_free", 32'(req.valid), 32'd0);
    tick();
    de_rdy = 1'b0;
    @(negedge clk);
    check("bnd_pc_10_hold", de_pc, 32'h10);
    check("bnd_req_issue_cycle", 32'(req.valid), 32'd0);
    tick();
    de_rdy = 1'b1;
    @(negedge clk);
    check("bnd_pc_10", de_pc, 32'h10);
    check("bnd_refill_valid", 32'(req.valid), 32'd1);
    check("bnd_refill_addr", req.addr, 32'h40);
    tick();
    de_rdy = 1'b0;
    @(negedge clk);
    check("bnd_pc_14", de_pc, 32'h14);
    tick();

    // Randomized traffic with occasional redirects.
    acc_start = acc_cnt;
    repeat (1500) begin
      de_rdy   = ($urandom_range(0, 3) != 0);
      redir_v  = ($urandom_range(0, 39) == 0);
      redir_pc = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    redir_v = 1'b0;
    check("random_progress", 32'((acc_cnt - acc_start) > 200), 32'd1);

    // Asynchronous reset with a response in flight.
    de_rdy = 1'b1;
    repeat (10) tick();
    wait_req(20, n, a, id);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_de_valid", 32'(de_v), 32'd0);
    check("async_rst_req_valid", 32'(req.valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_req(10, n, a, id);
    check("post_rst_req_cycle", 32'(n), 32'd2);
    check("post_rst_req_addr", a, RPC);
    check("post_rst_req_id", id, 32'h0);
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_buf.md
Name: fetch_buf

Overview:
- Instruction fetch buffer; sits directly upstream of the icache.
- Generates line fetch requests on fb_ic_req_nnn and accepts in-order line responses on ic_fb_rsp_nnn.
- Buffers returned lines in a small circular queue and hands one instruction per cycle to decode over a valid/ready handshake.
- Redirects (branch resolve) flush the queue; in-flight responses tagged with an old epoch are dropped.

Parameters:
- NUM_ENTRIES, 4, line-buffer entries; power of 2; also the cap on outstanding plus full lines.
- EPOCH_BITS, 3, redirect epoch width carried in the req/rsp id field.
- ICACHE_LATENCY, 1, icache response latency; used only by the assertion 2**EPOCH_BITS > ICACHE_LATENCY+1.
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- fb_ic_req_nnn  output  t_mem_req  line request: valid, id, addr.
- ic_fb_rsp_nnn  input  t_mem_rsp  line response: valid, id, data.W[CL_SZ_WORDS].
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  32  new fetch PC; word aligned.
- fb_de_valid  output  1  instruction available.
- fb_de_instr  output  32  instruction word.
- fb_de_pc  output  32  PC of fb_de_instr.
- de_fb_ready  input  1  decode accepts this cycle.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: fb_ic_req_nnn all fields 0; fb_de_valid=0; fetch_pc=RESET_PC; epoch=0; head=alloc=0; word_idx=0; all entries FREE.
- Entry state machine: FREE -> PEND on request issue -> FULL on matching response -> FREE when its last word is consumed or on redirect.
- Entry contents: base_pc and CL_SZ_WORDS data words.
- Issue:
  - fb_ic_req_nnn is registered.
  - Condition: entry[alloc] FREE, no redirect_valid, not in reset.
  - Next cycle drives valid=1, addr=fetch_pc, id={epoch, alloc} (id zero-extended).
  - Same edge: entry[alloc]=PEND, base_pc=fetch_pc, fetch_pc += CL_SZ_WORDS*4 (32-bit wrap), alloc++ mod NUM_ENTRIES.
  - Otherwise valid=0 next cycle. At most one request per cycle.
- No backpressure from the icache:
  - A request is never issued without a FREE entry, so every response has a home.
  - Addresses need not be line aligned; the icache returns CL_SZ_WORDS consecutive words.
- Response capture:
  - Condition: rsp.valid, id epoch field == epoch, and entry[id index] is PEND.
  - Action: store data, entry becomes FULL at the next edge.
  - Any other response is silently dropped. A non-stale response to a non-PEND entry is an assertion failure.
- Delivery (combinational from state):
  - fb_de_valid = entry[head] FULL && !redirect_valid.
  - fb_de_instr = data.W[word_idx]; fb_de_pc = base_pc + 4*word_idx.
  - On valid&&ready: word_idx++. At word_idx==CL_SZ_WORDS-1 the entry goes FREE, head++ (wrap), word_idx=0.
  - With ready low, outputs hold stable.
- Simultaneous events:
  - Consume-free and issue-allocate of the same entry in one cycle is legal.
  - The freed entry is usable for issue the following cycle (no same-cycle bypass of the FREE check).
- Redirect (priority over everything):
  - Same cycle: no issue, no capture, no delivery.
  - Next edge: all entries FREE, head=alloc=0, word_idx=0, epoch++ (wrap), fetch_pc=redirect_pc, request valid=0.
  - First post-redirect request appears 2 edges after redirect.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation clears everything asynchronously. Responses returning after reset carry epoch 0 with a PEND-free queue and are dropped.

Optional Feature:
- Macro: FB_RSP_BYPASS_EN.
- When defined: if the queue is empty (entry[head] PEND, word_idx=0) and a capturable response targets head, fb_de_valid=1 in the response cycle with instr=rsp.data.W[0], pc=base_pc.
  - If accepted, the entry is written FULL with word_idx=1. For CL_SZ_WORDS==1 it is freed directly.
- When undefined: the first instruction of a line is visible the cycle after the response (one extra cycle).

Test Plan (CL_SZ_WORDS=4, NUM_ENTRIES=4, icache LATENCY=1):
- Reset release, RESET_PC=0, ready=1 -> requests addr 0x0,0x10,0x20,0x30 on consecutive cycles; ids 0..3; decode sees pc 0x0,0x4,... contiguous; first instr 2 cycles after first request (1 with bypass).
- ready=0 held -> exactly 4 requests issued, then valid=0 on fb_ic_req_nnn; fb_de_pc stays 0x0 stable; after ready=1 and one line drained, request addr 0x40 follows.
- redirect_valid with redirect_pc=0x104 while 2 lines PEND -> their responses (old epoch) dropped; next request addr 0x104 id epoch=1; first delivered pc 0x104, then 0x108.
- redirect on 3 consecutive cycles, pcs 0x200/0x300/0x400 -> only 0x400 fetched; epoch=3; no instruction from 0x200/0x300 delivered.
- ready toggled 1,0,1,0 across a line boundary at pc 0xC->0x10 -> no word skipped or duplicated; entry freed exactly on acceptance of pc 0xC.
- Reset asserted asynchronously mid-stream with a response in flight -> fb_de_valid and request valid drop to 0 immediately; post-reset first request addr RESET_PC, stale response ignored.
